sprite_render: RTL and testbench
================================

SPRITE_RENDER -- requirements
Module: sprite_render

Interface
REQ-001 SHALL have parameter SPR_W, default 64: sprite width in pixels.
REQ-002 SHALL have parameter SPR_H, default 64: sprite height in pixels.
REQ-003 SHALL have parameter KEY_RGB, default 12'hF0F: transparent colour key.
REQ-004 SHALL have parameter N_FRAMES, default 5: number of animation frames in the ROM.
REQ-005 SHALL have port pixel_clk, input, 1: pixel clock.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port hcnt, input, 10: current horizontal pixel position.
REQ-008 SHALL have port vcnt, input, 10: current vertical line.
REQ-009 SHALL have port video_on, input, 1: hcnt/vcnt are inside the 640x480 active area.
REQ-010 SHALL have port frame_start, input, 1: one-cycle pulse at the start of vertical blanking.
REQ-011 SHALL have port ActionSel, input, 3: animation frame index from the motion stage.
REQ-012 SHALL have port DogPos_x, input, 10: sprite left edge, 0..640.
REQ-013 SHALL have port DogPos_y, input, 9: sprite top edge.
REQ-014 SHALL have port bg_rgb, input, 12: background colour for the current pixel.
REQ-015 SHALL have port rgb, output, 12: final pixel colour.
REQ-016 SHALL have port sprite_hit, output, 1: rgb comes from an opaque sprite pixel.

Function
REQ-017 SHALL latch ActionSel, DogPos_x and DogPos_y into shadow registers only on frame_start, so the sprite never tears mid-frame.
REQ-018 SHALL map a latched ActionSel >= N_FRAMES to frame 0.
REQ-019 Stage 1 SHALL compute in_box = video_on & (hcnt >= x) & (hcnt < x+SPR_W) & (vcnt >= y) & (vcnt < y+SPR_H), using 11-bit sums with no wrap.
REQ-020 Stage 1 SHALL register rom_addr = frame*SPR_W*SPR_H + (vcnt-y)*SPR_W + (hcnt-x), 15 bits; when in_box=0, rom_addr SHALL hold its previous value.
REQ-021 The ROM SHALL be a synchronous read, with data valid one cycle after the address is registered.
REQ-022 Stage 2 SHALL output rgb = rom_data when in_box_d & (rom_data != KEY_RGB); rgb = bg_rgb_d2 when video_on_d2; otherwise 12'h000.
REQ-023 Total latency from hcnt/vcnt/bg_rgb/video_on to rgb/sprite_hit SHALL be exactly 2 pixel_clk cycles; video_on and bg_rgb SHALL be delayed 2 stages to stay aligned.
REQ-024 sprite_hit SHALL be 1 exactly when rgb was taken from rom_data.
REQ-025 DogPos_x = 640 SHALL yield no hit anywhere, because the sprite is fully off-screen.
REQ-026 With DogPos_x in 577..639, only the columns with hcnt <= 639 SHALL render, with no wrap to column 0.
REQ-027 If frame_start coincides with an active pixel, the pixel in flight SHALL use the old shadow values and the following cycle SHALL use the new ones.

Reset
REQ-028 On reset, shadow registers SHALL be cleared to frame=0, x=0, y=0.
REQ-029 On reset, every pipeline register SHALL be cleared, and rgb=12'h000, sprite_hit=0 from the next edge on.
REQ-030 A reset asserted mid-line SHALL take priority over frame_start; output SHALL resume valid 2 cycles after release.

Structure
REQ-031 SPR_W, SPR_H, KEY_RGB, N_FRAMES, H_ACTIVE=640 and V_ACTIVE=480 SHALL live in the shared display package.
REQ-032 The ROM SHALL be the sub-module sprite_rom: 15-bit address, 12-bit data, registered output, initialised from a memory file of N_FRAMES*SPR_W*SPR_H words.

Verification
REQ-033 Reset held 3 cycles, video_on=1, bg_rgb=12'h0A0 -> rgb=12'h000 and sprite_hit=0 during reset; rgb=12'h0A0 from 2 cycles after release when outside the box.
REQ-034 Latch x=100, y=300, frame=2 via frame_start; drive hcnt=100, vcnt=300 -> 2 cycles later rgb = ROM[8192] unless that word is KEY_RGB.
REQ-035 ROM word equal to 12'hF0F inside the box -> rgb=bg_rgb, sprite_hit=0.
REQ-036 Change DogPos_x from 100 to 120 mid-frame without frame_start -> rendering unchanged until the next frame_start.
REQ-037 Latch x=600 -> hits only for hcnt 600..639; latch x=640 -> zero hits over a whole frame.
REQ-038 Latch ActionSel=3'd6 -> addresses use frame 0 base; video_on=0 -> rgb=12'h000.

Source files
------------

// File: rtl/sprite_render_pkg.sv
// rtl/sprite_render_pkg.sv - shared display constants and sprite image content
package sprite_render_pkg;

    localparam int          SPR_W    = 64;
    localparam int          SPR_H    = 64;
    localparam logic [11:0] KEY_RGB  = 12'hF0F;
    localparam int          N_FRAMES = 5;
    localparam int          H_ACTIVE = 640;
    localparam int          V_ACTIVE = 480;

    // Image content: frame number in the top nibble, low address byte below,
    // and a transparent pixel at the last column of every 64-word group.
    function automatic logic [11:0] rom_word(input logic [14:0] addr);
        if (addr[5:0] == 6'h3F) begin
            return KEY_RGB;
        end
        return {addr[14:12], 1'b0, addr[7:0]};
    endfunction

endpackage

// File: rtl/sprite_rom.sv
// rtl/sprite_rom.sv - synchronous-read sprite image ROM, registered output
module sprite_rom
    import sprite_render_pkg::*;
#(
    parameter int DEPTH = N_FRAMES * SPR_W * SPR_H
) (
    input  logic        pixel_clk,
    input  logic        reset,
    input  logic [14:0] addr,
    output logic [11:0] data
);

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            data <= 12'h000;
        end else if (int'(addr) < DEPTH) begin
            data <= rom_word(addr);
        end else begin
            data <= 12'h000;
        end
    end

endmodule

// File: rtl/sprite_render.sv
// rtl/sprite_render.sv - two-stage sprite overlay with colour-key transparency
module sprite_render
    import sprite_render_pkg::*;
#(
    parameter int          SPR_W    = sprite_render_pkg::SPR_W,
    parameter int          SPR_H    = sprite_render_pkg::SPR_H,
    parameter logic [11:0] KEY_RGB  = sprite_render_pkg::KEY_RGB,
    parameter int          N_FRAMES = sprite_render_pkg::N_FRAMES
) (
    input  logic        pixel_clk,
    input  logic        reset,
    input  logic [9:0]  hcnt,
    input  logic [9:0]  vcnt,
    input  logic        video_on,
    input  logic        frame_start,
    input  logic [2:0]  ActionSel,
    input  logic [9:0]  DogPos_x,
    input  logic [8:0]  DogPos_y,
    input  logic [11:0] bg_rgb,
    output logic [11:0] rgb,
    output logic        sprite_hit
);

    localparam int FRAME_WORDS = SPR_W * SPR_H;

    logic [2:0]  act_q;
    logic [9:0]  x_q;
    logic [8:0]  y_q;
    logic [2:0]  frame_sel;
    logic [10:0] x_end;
    logic [10:0] y_end;
    logic        in_box;
    logic [9:0]  dx;
    logic [9:0]  dy;
    logic [14:0] addr_next;

    logic        in_box_d1, in_box_d2;
    logic        video_on_d1, video_on_d2;
    logic [11:0] bg_d1, bg_d2;
    logic [14:0] rom_addr;
    logic [11:0] rom_data;

    // Shadow position/frame only move at vertical blanking so a frame never tears
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            act_q <= 3'd0;
            x_q   <= 10'd0;
            y_q   <= 9'd0;
        end else if (frame_start) begin
            act_q <= ActionSel;
            x_q   <= DogPos_x;
            y_q   <= DogPos_y;
        end
    end

    always_comb begin
        frame_sel = (int'(act_q) >= N_FRAMES) ? 3'd0 : act_q;
        x_end     = {1'b0, x_q} + 11'(SPR_W);
        y_end     = {2'b0, y_q} + 11'(SPR_H);
        in_box    = video_on
                    && ({1'b0, hcnt} >= {1'b0, x_q}) && ({1'b0, hcnt} < x_end)
                    && ({1'b0, vcnt} >= {2'b0, y_q}) && ({1'b0, vcnt} < y_end);
        dx        = hcnt - x_q;
        dy        = vcnt - {1'b0, y_q};
        addr_next = 15'(int'(frame_sel) * FRAME_WORDS)
                  + 15'(int'(dy) * SPR_W)
                  + 15'(dx);
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            in_box_d1   <= 1'b0;
            video_on_d1 <= 1'b0;
            bg_d1       <= 12'h000;
            rom_addr    <= 15'd0;
            in_box_d2   <= 1'b0;
            video_on_d2 <= 1'b0;
            bg_d2       <= 12'h000;
        end else begin
            in_box_d1   <= in_box;
            video_on_d1 <= video_on;
            bg_d1       <= bg_rgb;
            if (in_box) begin
                rom_addr <= addr_next;
            end
            in_box_d2   <= in_box_d1;
            video_on_d2 <= video_on_d1;
            bg_d2       <= bg_d1;
        end
    end

    sprite_rom #(
        .DEPTH (N_FRAMES * FRAME_WORDS)
    ) u_rom (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .addr      (rom_addr),
        .data      (rom_data)
    );

    always_comb begin
        rgb        = 12'h000;
        sprite_hit = 1'b0;
        if (in_box_d2 && (rom_data != KEY_RGB)) begin
            rgb        = rom_data;
            sprite_hit = 1'b1;
        end else if (video_on_d2) begin
            rgb = bg_d2;
        end
    end

endmodule

// File: tb/tb_sprite_render.sv
// tb/tb_sprite_render.sv - directed self-checking bench for sprite_render
module tb_sprite_render;

    logic        pixel_clk = 1'b0;
    logic        reset;
    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    logic        video_on;
    logic        frame_start;
    logic [2:0]  ActionSel;
    logic [9:0]  DogPos_x;
    logic [8:0]  DogPos_y;
    logic [11:0] bg_rgb;
    logic [11:0] rgb;
    logic        sprite_hit;

    int n_vec = 0;
    int n_err = 0;

    sprite_render dut (
        .pixel_clk   (pixel_clk),
        .reset       (reset),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .video_on    (video_on),
        .frame_start (frame_start),
        .ActionSel   (ActionSel),
        .DogPos_x    (DogPos_x),
        .DogPos_y    (DogPos_y),
        .bg_rgb      (bg_rgb),
        .rgb         (rgb),
        .sprite_hit  (sprite_hit)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic tick(input int n);
        repeat (n) @(posedge pixel_clk);
        #1;
    endtask

    task automatic set_pixel(input int h, input int v, input logic von, input logic [11:0] bg);
        hcnt     = 10'(h);
        vcnt     = 10'(v);
        video_on = von;
        bg_rgb   = bg;
    endtask

    task automatic latch(input int x, input int y, input int act);
        DogPos_x    = 10'(x);
        DogPos_y    = 9'(y);
        ActionSel   = 3'(act);
        video_on    = 1'b0;
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    // Streams one full row; output shown after iteration h belongs to pixel h-1
    task automatic sweep_row(input int v, output int hits, output int low_hits,
                             output logic [11:0] rgb_last);
        hits = 0;
        low_hits = 0;
        rgb_last = 12'h000;
        for (int h = 0; h <= 640; h++) begin
            if (h < 640) set_pixel(h, v, 1'b1, 12'h00F);
            else         video_on = 1'b0;
            tick(1);
            if (h >= 1 && sprite_hit) begin
                hits++;
                if (h - 1 < 600) low_hits++;
            end
            if (h == 640) rgb_last = rgb;
        end
        tick(2);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        set_pixel(300, 200, 1'b1, 12'h0A0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            n_vec++;
            if (rgb !== 12'h000 || sprite_hit !== 1'b0) begin
                $display("FAIL reset_hold[%0d]: rgb=%h hit=%b, want rgb=000 hit=0", i, rgb, sprite_hit);
                n_err++;
            end
        end
        reset = 1'b0;
        tick(1);
        n_vec++;
        if (rgb !== 12'h000) begin
            $display("FAIL reset_release_1: rgb=%h, want 000", rgb);
            n_err++;
        end
        tick(1);
        n_vec++;
        if (rgb !== 12'h0A0 || sprite_hit !== 1'b0) begin
            $display("FAIL reset_release_2: rgb=%h hit=%b, want rgb=0a0 hit=0", rgb, sprite_hit);
            n_err++;
        end
        // cleared shadow: frame 0 at origin, pixel (5,3) -> word 197
        set_pixel(5, 3, 1'b1, 12'h0A0);
        tick(2);
        n_vec++;
        if (rgb !== 12'h0C5 || sprite_hit !== 1'b1) begin
            $display("FAIL reset_shadow: rgb=%h hit=%b, want rgb=0c5 hit=1", rgb, sprite_hit);
            n_err++;
        end
    endtask

    task automatic test_hit;
        int          hv[5][2];
        logic [11:0] ev[5];
        logic        eh[5];
        latch(100, 300, 2);
        set_pixel(99, 300, 1'b1, 12'h123);
        tick(1);
        set_pixel(100, 300, 1'b1, 12'h123);
        tick(1);
        n_vec++;
        if (rgb !== 12'h123 || sprite_hit !== 1'b0) begin
            $display("FAIL latency_1cyc: rgb=%h hit=%b, want rgb=123 hit=0", rgb, sprite_hit);
            n_err++;
        end
        tick(1);
        n_vec++;
        if (rgb !== 12'h400 || sprite_hit !== 1'b1) begin
            $display("FAIL rom_8192: rgb=%h hit=%b, want rgb=400 hit=1", rgb, sprite_hit);
            n_err++;
        end
        hv = '{'{105, 310}, '{162, 363}, '{164, 300}, '{100, 364}, '{100, 299}};
        ev = '{12'h485, 12'h4FE, 12'h123, 12'h123, 12'h123};
        eh = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            set_pixel(hv[i][0], hv[i][1], 1'b1, 12'h123);
            tick(2);
            n_vec++;
            if (rgb !== ev[i] || sprite_hit !== eh[i]) begin
                $display("FAIL box_pixel(%0d,%0d): rgb=%h hit=%b, want rgb=%h hit=%b",
                         hv[i][0], hv[i][1], rgb, sprite_hit, ev[i], eh[i]);
                n_err++;
            end
        end
    endtask

    task automatic test_key;
        set_pixel(163, 300, 1'b1, 12'h123);
        tick(2);
        n_vec++;
        if (rgb !== 12'h123 || sprite_hit !== 1'b0) begin
            $display("FAIL color_key: rgb=%h hit=%b, want rgb=123 hit=0", rgb, sprite_hit);
            n_err++;
        end
    endtask

    task automatic test_no_tear;
        DogPos_x = 10'd120;
        set_pixel(100, 300, 1'b1, 12'h123);
        tick(2);
        n_vec++;
        if (rgb !== 12'h400 || sprite_hit !== 1'b1) begin
            $display("FAIL no_tear_old: rgb=%h hit=%b, want rgb=400 hit=1", rgb, sprite_hit);
            n_err++;
        end
        set_pixel(165, 300, 1'b1, 12'h123);
        tick(2);
        n_vec++;
        if (rgb !== 12'h123 || sprite_hit !== 1'b0) begin
            $display("FAIL no_tear_new: rgb=%h hit=%b, want rgb=123 hit=0", rgb, sprite_hit);
            n_err++;
        end
        latch(120, 300, 2);
        set_pixel(100, 300, 1'b1, 12'h123);
        tick(2);
        n_vec++;
        if (rgb !== 12'h123 || sprite_hit !== 1'b0) begin
            $display("FAIL moved_old_col: rgb=%h hit=%b, want rgb=123 hit=0", rgb, sprite_hit);
            n_err++;
        end
        set_pixel(120, 300, 1'b1, 12'h123);
        tick(2);
        n_vec++;
        if (rgb !== 12'h400 || sprite_hit !== 1'b1) begin
            $display("FAIL moved_new_col: rgb=%h hit=%b, want rgb=400 hit=1", rgb, sprite_hit);
            n_err++;
        end
    endtask

    task automatic test_inflight;
        DogPos_x    = 10'd200;
        frame_start = 1'b1;
        set_pixel(120, 300, 1'b1, 12'h123);
        tick(1);
        frame_start = 1'b0;
        set_pixel(200, 300, 1'b1, 12'h123);
        tick(1);
        n_vec++;
        if (rgb !== 12'h400 || sprite_hit !== 1'b1) begin
            $display("FAIL inflight_old: rgb=%h hit=%b, want rgb=400 hit=1", rgb, sprite_hit);
            n_err++;
        end
        tick(1);
        n_vec++;
        if (rgb !== 12'h400 || sprite_hit !== 1'b1) begin
            $display("FAIL inflight_new: rgb=%h hit=%b, want rgb=400 hit=1", rgb, sprite_hit);
            n_err++;
        end
    endtask

    task automatic test_right_edge;
        int          hits, low_hits, total;
        logic [11:0] last;
        latch(600, 0, 1);
        sweep_row(10, hits, low_hits, last);
        n_vec++;
        if (hits !== 40 || low_hits !== 0) begin
            $display("FAIL edge_600_hits: hits=%0d low=%0d, want hits=40 low=0", hits, low_hits);
            n_err++;
        end
        n_vec++;
        if (last !== 12'h2A7) begin
            $display("FAIL edge_600_col639: rgb=%h, want 2a7", last);
            n_err++;
        end
        latch(640, 0, 1);
        total = 0;
        for (int r = 0; r < 3; r++) begin
            sweep_row(r * 32 - (r == 2 ? 1 : 0), hits, low_hits, last);
            total += hits;
        end
        n_vec++;
        if (total !== 0) begin
            $display("FAIL edge_640_hits: hits=%0d, want 0", total);
            n_err++;
        end
    endtask

    task automatic test_frame_map;
        int          acts[3];
        logic [11:0] ev[3];
        acts = '{6, 4, 5};
        ev   = '{12'h0C5, 12'h8C5, 12'h0C5};
        for (int i = 0; i < 3; i++) begin
            latch(0, 0, acts[i]);
            set_pixel(5, 3, 1'b1, 12'h123);
            tick(2);
            n_vec++;
            if (rgb !== ev[i] || sprite_hit !== 1'b1) begin
                $display("FAIL frame_map_act%0d: rgb=%h hit=%b, want rgb=%h hit=1",
                         acts[i], rgb, sprite_hit, ev[i]);
                n_err++;
            end
        end
        set_pixel(5, 3, 1'b0, 12'h123);
        tick(2);
        n_vec++;
        if (rgb !== 12'h000 || sprite_hit !== 1'b0) begin
            $display("FAIL video_off: rgb=%h hit=%b, want rgb=000 hit=0", rgb, sprite_hit);
            n_err++;
        end
    endtask

    task automatic test_reset_mid_line;
        latch(0, 0, 4);
        set_pixel(5, 3, 1'b1, 12'h123);
        DogPos_x    = 10'd300;
        ActionSel   = 3'd2;
        reset       = 1'b1;
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        n_vec++;
        if (rgb !== 12'h000 || sprite_hit !== 1'b0) begin
            $display("FAIL midline_reset: rgb=%h hit=%b, want rgb=000 hit=0", rgb, sprite_hit);
            n_err++;
        end
        reset = 1'b0;
        tick(1);
        n_vec++;
        if (rgb !== 12'h000) begin
            $display("FAIL midline_release_1: rgb=%h, want 000", rgb);
            n_err++;
        end
        tick(1);
        n_vec++;
        if (rgb !== 12'h0C5 || sprite_hit !== 1'b1) begin
            $display("FAIL midline_priority: rgb=%h hit=%b, want rgb=0c5 hit=1", rgb, sprite_hit);
            n_err++;
        end
    endtask

    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        ActionSel   = 3'd0;
        DogPos_x    = 10'd0;
        DogPos_y    = 9'd0;
        set_pixel(0, 0, 1'b0, 12'h000);
        test_reset();
        test_hit();
        test_key();
        test_no_tear();
        test_inflight();
        test_right_edge();
        test_frame_map();
        test_reset_mid_line();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
